alu_cop0_core: RTL and testbench
================================

ALU_COP0_CORE -- requirements
Module: alu_cop0_core

Interface
REQ-001 Reset iRST SHALL be synchronous, active-high; clock iCLK; all state SHALL update on rising iCLK.
REQ-002 iCLK in 1: clock. iRST in 1: synchronous reset.
REQ-003 iALUOp in 2: 00=add, 01=branch compare, 10=R-type by iFunct, 11=I-type by iOpcode.
REQ-004 iOpcode in 6, iFunct in 6, iRt in 5: instruction fields.
REQ-005 oControlSignal out 5: decoded ALU operation code (REQ-012).
REQ-006 iA in 32, iB in 32, iShamt in 5: operands. oALUresult out 32, oZero out 1, oOverflow out 1.
REQ-007 iReadRegister in 5, iWriteRegister in 5, iWriteData in 32, iRegWrite in 1, oReadData out 32: COP0 register access.
REQ-008 iEret in 1, iExcOccurred in 1, iBranchDelay in 1, iExcCode in 5, iPendingInterrupt in 8: COP0 event inputs.
REQ-009 oInterruptMask out 8, oUserMode out 1, oExcLevel out 1: COP0 status outputs.
REQ-010 iRegDispSelect in 5, oRegDisp out 32: debug read port.

Function
REQ-011 Decode SHALL be combinational. ALUOp 00 -> ADD. ALUOp 01 -> SUB, except iOpcode=000001 (REGIMM): iRt 00000/10000 -> LTZ, iRt 00001/10001 -> GEZ.
REQ-012 Op codes: AND0 OR1 ADD2 ADDU3 SUB4 SUBU5 SLT6 SLTU7 NOR8 XOR9 SLL10 SRL11 SRA12 SLLV13 SRLV14 SRAV15 LUI16 MULT17 MULTU18 DIV19 DIVU20 MFHI21 MFLO22 MTHI23 MTLO24 LTZ25 GEZ26. Unlisted codes SHALL give result 0.
REQ-013 R-type funct map: 20 ADD, 21 ADDU, 22 SUB, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU, 10 MFHI, 12 MFLO, 11 MTHI, 13 MTLO (hex). Other funct -> ADD.
REQ-014 I-type opcode map: 08 ADD, 09 ADDU, 0A SLT, 0B SLTU, 0C AND, 0D OR, 0E XOR, 0F LUI (hex). Other opcodes -> ADD.
REQ-015 Result, combinational: arithmetic mod 2^32. SLT signed, SLTU unsigned, result 1/0. Shift-immediate ops use iShamt on iB. Variable shifts use iA[4:0] on iB. LUI = {iB[15:0],16'h0}.
REQ-016 LTZ result = 0 if iA signed <0, else 1. GEZ result = 0 if iA >=0, else 1. oZero = (oALUresult==0) for all ops.
REQ-017 oOverflow = 1 only for ADD/SUB on signed two's-complement overflow; 0 for ADDU/SUBU and all others.
REQ-018 HI/LO 32-bit registers, written at the clock edge: MULT/MULTU {HI,LO} <= 64-bit product. DIV/DIVU LO <= quotient, HI <= remainder; divisor 0 leaves HI/LO unchanged. MTHI/MTLO load iA. MFHI/MFLO output HI/LO combinationally.
REQ-019 COP0 registers: 12 Status (IE bit0, EXL bit1, UM bit4, IM bits15:8), 13 Cause (BD bit31, IP bits15:8, ExcCode bits6:2), 14 EPC. Other indices read 0 and ignore writes.
REQ-020 oReadData = reg[iReadRegister] and oRegDisp = reg[iRegDispSelect], both combinational.
REQ-021 Cause.IP SHALL sample iPendingInterrupt every cycle.
REQ-022 Events are prioritized highest first: iExcOccurred, then iEret, then iRegWrite.
REQ-023 iExcOccurred: EPC <= iWriteData, Cause.ExcCode <= iExcCode, Cause.BD <= iBranchDelay, Status.EXL <= 1.
REQ-024 iEret: Status.EXL <= 0.
REQ-025 iRegWrite: reg[iWriteRegister] <= iWriteData. On Cause, only bits 9:8 are writable.
REQ-026 oInterruptMask = Cause.IP & Status.IM when Status.IE=1 and EXL=0, else 0. oUserMode = Status.UM. oExcLevel = Status.EXL.

Reset
REQ-027 On iRST: HI=LO=0, Status=0x0000FF11, Cause=0, EPC=0. Reset SHALL override all events in the same cycle.

Verification
REQ-028 iALUOp=10, funct 20, iA=0x7FFFFFFF, iB=1 -> result 0x80000000, oOverflow=1. Same with funct 21 -> oOverflow=0.
REQ-029 iALUOp=10, funct 2A, iA=0xFFFFFFFF, iB=1 -> result 1. Funct 2B with the same operands -> result 0.
REQ-030 MULT, iA=0xFFFFFFFE, iB=3, then MFHI/MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. DIV 7/2 -> LO=3, HI=1.
REQ-031 iALUOp=01, opcode 01, iRt=1, iA=5 -> oZero=1. Same with iA=0xFFFFFFFF -> oZero=0.
REQ-032 After reset, iExcOccurred=1, iExcCode=12, iWriteData=0x00400010 -> EPC=0x00400010, Cause=0x00000030, oExcLevel=1. Then iEret -> oExcLevel=0.
REQ-033 Status=0x0000FF11, iPendingInterrupt=0x04 -> oInterruptMask=0x04 after one clock. Write Status=0x0000FF10 -> oInterruptMask=0.

Source files
------------

// File: rtl/alu_cop0_core.sv
// alu_cop0_core: MIPS-style ALU with its control decoder, HI/LO multiply/divide
// registers and a minimal coprocessor-0 (Status, Cause, EPC).
//
// Ports:
//   iCLK, iRST            clock, synchronous active-high reset
//   iALUOp/iOpcode/iFunct/iRt   instruction fields -> oControlSignal (ALU op code)
//   iA, iB, iShamt        operands -> oALUresult, oZero, oOverflow
//   iReadRegister/oReadData, iRegDispSelect/oRegDisp   COP0 read ports
//   iWriteRegister/iWriteData/iRegWrite                COP0 write port
//   iExcOccurred/iExcCode/iBranchDelay/iEret/iPendingInterrupt   COP0 events
//   oInterruptMask, oUserMode, oExcLevel               COP0 status outputs
module alu_cop0_core (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [1:0]  iALUOp,
  input  logic [5:0]  iOpcode,
  input  logic [5:0]  iFunct,
  input  logic [4:0]  iRt,
  output logic [4:0]  oControlSignal,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [4:0]  iShamt,
  output logic [31:0] oALUresult,
  output logic        oZero,
  output logic        oOverflow,
  input  logic [4:0]  iReadRegister,
  input  logic [4:0]  iWriteRegister,
  input  logic [31:0] iWriteData,
  input  logic        iRegWrite,
  output logic [31:0] oReadData,
  input  logic        iEret,
  input  logic        iExcOccurred,
  input  logic        iBranchDelay,
  input  logic [4:0]  iExcCode,
  input  logic [7:0]  iPendingInterrupt,
  output logic [7:0]  oInterruptMask,
  output logic        oUserMode,
  output logic        oExcLevel,
  input  logic [4:0]  iRegDispSelect,
  output logic [31:0] oRegDisp
);

  localparam logic [4:0] OpAnd  = 5'd0,  OpOr   = 5'd1,  OpAdd  = 5'd2,  OpAddu = 5'd3;
  localparam logic [4:0] OpSub  = 5'd4,  OpSubu = 5'd5,  OpSlt  = 5'd6,  OpSltu = 5'd7;
  localparam logic [4:0] OpNor  = 5'd8,  OpXor  = 5'd9,  OpSll  = 5'd10, OpSrl  = 5'd11;
  localparam logic [4:0] OpSra  = 5'd12, OpSllv = 5'd13, OpSrlv = 5'd14, OpSrav = 5'd15;
  localparam logic [4:0] OpLui  = 5'd16, OpMult = 5'd17, OpMultu = 5'd18, OpDiv = 5'd19;
  localparam logic [4:0] OpDivu = 5'd20, OpMfhi = 5'd21, OpMflo = 5'd22, OpMthi = 5'd23;
  localparam logic [4:0] OpMtlo = 5'd24, OpLtz  = 5'd25, OpGez  = 5'd26;

  localparam logic [31:0] StatusReset = 32'h0000_FF11;

  logic [4:0]  ctrl;
  logic [31:0] hiQ, loQ;
  logic [31:0] statusQ, causeQ, epcQ;
  logic [31:0] sum, diff;
  logic [63:0] prodS, prodU;
  logic [31:0] quoS, remS, quoU, remU;

  // ---------------- decode ----------------
  always_comb begin
    ctrl = OpAdd;
    case (iALUOp)
      2'b01: begin
        ctrl = OpSub;
        // REGIMM branches: rt bit 4 selects the linking variant, same compare
        if (iOpcode == 6'h01) begin
          if (iRt == 5'h00 || iRt == 5'h10) ctrl = OpLtz;
          else if (iRt == 5'h01 || iRt == 5'h11) ctrl = OpGez;
        end
      end
      2'b10: begin
        case (iFunct)
          6'h20: ctrl = OpAdd;   6'h21: ctrl = OpAddu;  6'h22: ctrl = OpSub;
          6'h23: ctrl = OpSubu;  6'h24: ctrl = OpAnd;   6'h25: ctrl = OpOr;
          6'h26: ctrl = OpXor;   6'h27: ctrl = OpNor;   6'h2A: ctrl = OpSlt;
          6'h2B: ctrl = OpSltu;  6'h00: ctrl = OpSll;   6'h02: ctrl = OpSrl;
          6'h03: ctrl = OpSra;   6'h04: ctrl = OpSllv;  6'h06: ctrl = OpSrlv;
          6'h07: ctrl = OpSrav;  6'h18: ctrl = OpMult;  6'h19: ctrl = OpMultu;
          6'h1A: ctrl = OpDiv;   6'h1B: ctrl = OpDivu;  6'h10: ctrl = OpMfhi;
          6'h12: ctrl = OpMflo;  6'h11: ctrl = OpMthi;  6'h13: ctrl = OpMtlo;
          default: ctrl = OpAdd;
        endcase
      end
      2'b11: begin
        case (iOpcode)
          6'h08: ctrl = OpAdd;   6'h09: ctrl = OpAddu;  6'h0A: ctrl = OpSlt;
          6'h0B: ctrl = OpSltu;  6'h0C: ctrl = OpAnd;   6'h0D: ctrl = OpOr;
          6'h0E: ctrl = OpXor;   6'h0F: ctrl = OpLui;
          default: ctrl = OpAdd;
        endcase
      end
      default: ctrl = OpAdd;
    endcase
  end

  assign oControlSignal = ctrl;

  // ---------------- datapath ----------------
  assign sum  = iA + iB;
  assign diff = iA - iB;
  // Low 64 bits of the sign-extended product equal the signed product
  assign prodS = {{32{iA[31]}}, iA} * {{32{iB[31]}}, iB};
  assign prodU = {32'b0, iA} * {32'b0, iB};
  assign quoS  = $signed(iA) / $signed(iB);
  assign remS  = $signed(iA) % $signed(iB);
  assign quoU  = iA / iB;
  assign remU  = iA % iB;

  always_comb begin
    oALUresult = 32'h0;
    case (ctrl)
      OpAnd:  oALUresult = iA & iB;
      OpOr:   oALUresult = iA | iB;
      OpAdd, OpAddu: oALUresult = sum;
      OpSub, OpSubu: oALUresult = diff;
      OpSlt:  oALUresult = {31'b0, $signed(iA) < $signed(iB)};
      OpSltu: oALUresult = {31'b0, iA < iB};
      OpNor:  oALUresult = ~(iA | iB);
      OpXor:  oALUresult = iA ^ iB;
      OpSll:  oALUresult = iB << iShamt;
      OpSrl:  oALUresult = iB >> iShamt;
      OpSra:  oALUresult = $unsigned($signed(iB) >>> iShamt);
      OpSllv: oALUresult = iB << iA[4:0];
      OpSrlv: oALUresult = iB >> iA[4:0];
      OpSrav: oALUresult = $unsigned($signed(iB) >>> iA[4:0]);
      OpLui:  oALUresult = {iB[15:0], 16'h0};
      OpMfhi: oALUresult = hiQ;
      OpMflo: oALUresult = loQ;
      // Branch compares yield 0 when the branch condition holds, so oZero means "taken"
      OpLtz:  oALUresult = iA[31] ? 32'd0 : 32'd1;
      OpGez:  oALUresult = iA[31] ? 32'd1 : 32'd0;
      default: oALUresult = 32'h0;
    endcase
  end

  assign oZero = (oALUresult == 32'h0);

  always_comb begin
    oOverflow = 1'b0;
    if (ctrl == OpAdd) oOverflow = (iA[31] == iB[31]) && (sum[31] != iA[31]);
    else if (ctrl == OpSub) oOverflow = (iA[31] != iB[31]) && (diff[31] != iA[31]);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hiQ <= 32'h0;
      loQ <= 32'h0;
    end else begin
      case (ctrl)
        OpMult:  {hiQ, loQ} <= prodS;
        OpMultu: {hiQ, loQ} <= prodU;
        OpDiv:   if (iB != 32'h0) begin loQ <= quoS; hiQ <= remS; end
        OpDivu:  if (iB != 32'h0) begin loQ <= quoU; hiQ <= remU; end
        OpMthi:  hiQ <= iA;
        OpMtlo:  loQ <= iA;
        default: ;
      endcase
    end
  end

  // ---------------- COP0 ----------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      statusQ <= StatusReset;
      causeQ  <= 32'h0;
      epcQ    <= 32'h0;
    end else begin
      causeQ[15:8] <= iPendingInterrupt;
      if (iExcOccurred) begin
        epcQ         <= iWriteData;
        causeQ[6:2]  <= iExcCode;
        causeQ[31]   <= iBranchDelay;
        statusQ[1]   <= 1'b1;
      end else if (iEret) begin
        statusQ[1]   <= 1'b0;
      end else if (iRegWrite) begin
        case (iWriteRegister)
          5'd12:   statusQ <= iWriteData;
          // Software-interrupt bits override this cycle's pending sample
          5'd13:   causeQ[9:8] <= iWriteData[9:8];
          5'd14:   epcQ <= iWriteData;
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] cop0Read(input logic [4:0] idx, input logic [31:0] st,
                                           input logic [31:0] ca, input logic [31:0] ep);
    case (idx)
      5'd12:   cop0Read = st;
      5'd13:   cop0Read = ca;
      5'd14:   cop0Read = ep;
      default: cop0Read = 32'h0;
    endcase
  endfunction

  assign oReadData = cop0Read(iReadRegister, statusQ, causeQ, epcQ);
  assign oRegDisp  = cop0Read(iRegDispSelect, statusQ, causeQ, epcQ);

  assign oInterruptMask = (statusQ[0] && !statusQ[1]) ? (causeQ[15:8] & statusQ[15:8]) : 8'h0;
  assign oUserMode      = statusQ[4];
  assign oExcLevel      = statusQ[1];

endmodule

// File: tb/tb_alu_cop0_core.sv
module tb_alu_cop0_core;
  logic        iCLK, iRST;
  logic [1:0]  iALUOp;
  logic [5:0]  iOpcode, iFunct;
  logic [4:0]  iRt, iShamt;
  logic [4:0]  oControlSignal;
  logic [31:0] iA, iB, oALUresult;
  logic        oZero, oOverflow;
  logic [4:0]  iReadRegister, iWriteRegister, iExcCode, iRegDispSelect;
  logic [31:0] iWriteData, oReadData, oRegDisp;
  logic        iRegWrite, iEret, iExcOccurred, iBranchDelay;
  logic [7:0]  iPendingInterrupt, oInterruptMask;
  logic        oUserMode, oExcLevel;

  alu_cop0_core dut (
    .iCLK(iCLK), .iRST(iRST), .iALUOp(iALUOp), .iOpcode(iOpcode), .iFunct(iFunct),
    .iRt(iRt), .oControlSignal(oControlSignal), .iA(iA), .iB(iB), .iShamt(iShamt),
    .oALUresult(oALUresult), .oZero(oZero), .oOverflow(oOverflow),
    .iReadRegister(iReadRegister), .iWriteRegister(iWriteRegister),
    .iWriteData(iWriteData), .iRegWrite(iRegWrite), .oReadData(oReadData),
    .iEret(iEret), .iExcOccurred(iExcOccurred), .iBranchDelay(iBranchDelay),
    .iExcCode(iExcCode), .iPendingInterrupt(iPendingInterrupt),
    .oInterruptMask(oInterruptMask), .oUserMode(oUserMode), .oExcLevel(oExcLevel),
    .iRegDispSelect(iRegDispSelect), .oRegDisp(oRegDisp)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;

  // Reference tables: ALU op number per funct / opcode, straight from the op listing
  int fmap[64];
  int imap[64];

  // Reference architectural state
  logic [31:0] mHi, mLo, mStatus, mEpc;
  logic [7:0]  mIp;
  logic [4:0]  mCode;
  logic        mBd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic alu(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                     input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b);
    iALUOp = op; iOpcode = opc; iFunct = fn; iRt = rt; iA = a; iB = b;
    #1;
  endtask

  task automatic clearEvents();
    iExcOccurred = 0; iEret = 0; iRegWrite = 0; iBranchDelay = 0;
  endtask

  task automatic doReset();
    iRST = 1; tick(); iRST = 0;
  endtask

  function automatic int expOp(input logic [1:0] op, input logic [5:0] opc,
                               input logic [5:0] fn, input logic [4:0] rt);
    if (op == 2'b00) return 2;
    if (op == 2'b01) begin
      if (opc == 6'h01 && (rt == 5'd0 || rt == 5'd16)) return 25;
      if (opc == 6'h01 && (rt == 5'd1 || rt == 5'd17)) return 26;
      return 4;
    end
    if (op == 2'b10) return fmap[fn];
    return imap[opc];
  endfunction

  function automatic logic [31:0] expRes(input int op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      0: return a & b;
      1: return a | b;
      2, 3: return a + b;
      4, 5: return a - b;
      6: return (sa < sb) ? 32'd1 : 32'd0;
      7: return (a < b) ? 32'd1 : 32'd0;
      8: return ~(a | b);
      9: return a ^ b;
      10: return b << sh;
      11: return b >> sh;
      12: return sb >>> sh;
      13: return b << a[4:0];
      14: return b >> a[4:0];
      15: return sb >>> a[4:0];
      16: return b * 32'd65536;
      21: return mHi;
      22: return mLo;
      25: return (sa < 0) ? 32'd0 : 32'd1;
      26: return (sa >= 0) ? 32'd0 : 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic expOvf(input int op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    int sa, sb;
    sa = a; sb = b;
    if (op == 2) s = longint'(sa) + longint'(sb);
    else if (op == 4) s = longint'(sa) - longint'(sb);
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] mCause();
    return {mBd, 15'b0, mIp, 1'b0, mCode, 2'b0};
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] idx);
    if (idx == 5'd12) return mStatus;
    if (idx == 5'd13) return mCause();
    if (idx == 5'd14) return mEpc;
    return 32'h0;
  endfunction

  task automatic modelReset();
    mHi = 0; mLo = 0; mStatus = 32'h0000_FF11; mEpc = 0; mIp = 0; mCode = 0; mBd = 0;
  endtask

  localparam int NFuncts = 24;
  logic [5:0] functs [NFuncts] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                   6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h11, 6'h13};
  int fcodes [NFuncts] = '{2, 3, 4, 5, 0, 1, 9, 8, 6, 7, 10, 11, 12, 13, 14, 15,
                           17, 18, 19, 20, 21, 22, 23, 24};
  logic [31:0] corners [4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  initial begin
    for (int i = 0; i < 64; i++) begin fmap[i] = 2; imap[i] = 2; end
    for (int i = 0; i < NFuncts; i++) fmap[functs[i]] = fcodes[i];
    for (int i = 8; i < 16; i++) imap[i] = (i == 8) ? 2 : (i == 9) ? 3 : (i == 10) ? 6 :
                                           (i == 11) ? 7 : (i == 12) ? 0 : (i == 13) ? 1 :
                                           (i == 14) ? 9 : 16;

    iALUOp = 0; iOpcode = 0; iFunct = 0; iRt = 0; iA = 0; iB = 0; iShamt = 0;
    iReadRegister = 12; iWriteRegister = 0; iWriteData = 0; iExcCode = 0;
    iRegDispSelect = 13; iPendingInterrupt = 0;
    clearEvents();

    // Reset state, with events asserted during reset to confirm reset wins
    iRST = 1; tick();
    iExcOccurred = 1; iRegWrite = 1; iWriteRegister = 14; iWriteData = 32'hDEAD_BEEF;
    iPendingInterrupt = 8'hFF;
    tick();
    iRegDispSelect = 14; #1;
    chk("rst_status", oReadData, 32'h0000_FF11);
    chk("rst_epc", oRegDisp, 32'h0);
    chk("rst_exl", {31'b0, oExcLevel}, 32'd0);
    chk("rst_um", {31'b0, oUserMode}, 32'd1);
    iRegDispSelect = 13; #1;
    chk("rst_cause", oRegDisp, 32'h0);
    clearEvents(); iPendingInterrupt = 0; iRST = 0;
    alu(2'b10, 0, 6'h10, 0, 0, 0);
    chk("rst_hi", oALUresult, 32'h0);

    // Add / slt corners
    alu(2'b10, 0, 6'h20, 0, 32'h7FFF_FFFF, 32'h1);
    chk("add_res", oALUresult, 32'h8000_0000);
    chk("add_ovf", {31'b0, oOverflow}, 32'd1);
    alu(2'b10, 0, 6'h21, 0, 32'h7FFF_FFFF, 32'h1);
    chk("addu_ovf", {31'b0, oOverflow}, 32'd0);
    alu(2'b10, 0, 6'h2A, 0, 32'hFFFF_FFFF, 32'h1);
    chk("slt_res", oALUresult, 32'd1);
    alu(2'b10, 0, 6'h2B, 0, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_res", oALUresult, 32'd0);

    // HI/LO
    alu(2'b10, 0, 6'h18, 0, 32'hFFFF_FFFE, 32'd3); tick();
    alu(2'b10, 0, 6'h10, 0, 0, 0);
    chk("mult_hi", oALUresult, 32'hFFFF_FFFF);
    alu(2'b10, 0, 6'h12, 0, 0, 0);
    chk("mult_lo", oALUresult, 32'hFFFF_FFFA);
    alu(2'b10, 0, 6'h1A, 0, 32'd7, 32'd2); tick();
    alu(2'b10, 0, 6'h12, 0, 0, 0);
    chk("div_lo", oALUresult, 32'd3);
    alu(2'b10, 0, 6'h1A, 0, 32'd9, 32'd0); tick();
    alu(2'b10, 0, 6'h10, 0, 0, 0);
    chk("div0_hi", oALUresult, 32'd1);
    alu(2'b10, 0, 6'h12, 0, 0, 0);
    chk("div0_lo", oALUresult, 32'd3);

    // Branch compare
    alu(2'b01, 6'h01, 0, 5'd1, 32'd5, 0);
    chk("gez_ctrl", {27'b0, oControlSignal}, 32'd26);
    chk("gez_zero", {31'b0, oZero}, 32'd1);
    alu(2'b01, 6'h01, 0, 5'd1, 32'hFFFF_FFFF, 0);
    chk("gez_neg_zero", {31'b0, oZero}, 32'd0);
    alu(2'b01, 6'h04, 0, 5'd1, 32'd5, 32'd5);
    chk("beq_ctrl", {27'b0, oControlSignal}, 32'd4);

    // Exception / eret
    doReset();
    iExcOccurred = 1; iExcCode = 5'd12; iWriteData = 32'h0040_0010; tick();
    clearEvents();
    iReadRegister = 14; iRegDispSelect = 13; #1;
    chk("exc_epc", oReadData, 32'h0040_0010);
    chk("exc_cause", oRegDisp, 32'h0000_0030);
    chk("exc_exl", {31'b0, oExcLevel}, 32'd1);
    iEret = 1; tick(); clearEvents();
    chk("eret_exl", {31'b0, oExcLevel}, 32'd0);

    // Interrupt mask
    doReset();
    iPendingInterrupt = 8'h04; #1;
    chk("im_before", {24'b0, oInterruptMask}, 32'h0);
    tick();
    chk("im_after", {24'b0, oInterruptMask}, 32'h04);
    iRegWrite = 1; iWriteRegister = 12; iWriteData = 32'h0000_FF10; tick(); clearEvents();
    chk("im_ie_off", {24'b0, oInterruptMask}, 32'h0);

    // Priority: exception beats a register write; eret beats a register write
    iExcOccurred = 1; iRegWrite = 1; iWriteRegister = 12; iWriteData = 32'h0; tick();
    clearEvents();
    iReadRegister = 12; #1;
    chk("prio_exc", oReadData, 32'h0000_FF12);
    iEret = 1; iRegWrite = 1; iWriteRegister = 12; iWriteData = 32'h5; tick(); clearEvents();
    chk("prio_eret", oReadData, 32'h0000_FF10);

    // Randomized run against the reference model
    doReset();
    modelReset();
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a, b;
      logic [4:0] sh;
      iALUOp = 2'($urandom_range(0, 3));
      iOpcode = ($urandom_range(0, 1) == 0) ? 6'h01 : 6'($urandom_range(0, 15));
      iFunct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, NFuncts - 1)];
      iRt = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1) * 16 + $urandom_range(0, 1));
      a = $urandom; b = $urandom; sh = 5'($urandom);
      if ($urandom_range(0, 3) == 0) a = corners[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = corners[$urandom_range(0, 3)];
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      iA = a; iB = b; iShamt = sh;
      iReadRegister = 5'($urandom_range(10, 16));
      iRegDispSelect = 5'($urandom_range(10, 16));
      iPendingInterrupt = 8'($urandom);
      iExcOccurred = ($urandom_range(0, 9) == 0);
      iEret = ($urandom_range(0, 5) == 0);
      iRegWrite = ($urandom_range(0, 2) == 0);
      iWriteRegister = 5'($urandom);
      if (iWriteRegister == 5'd13) iWriteRegister = 5'd14;
      iWriteData = ($urandom_range(0, 1) == 0) ? $urandom : (32'h0000_FF00 | 32'($urandom_range(0, 31)));
      iExcCode = 5'($urandom); iBranchDelay = 1'($urandom);
      #1;
      op = expOp(iALUOp, iOpcode, iFunct, iRt);
      chk("r_ctrl", {27'b0, oControlSignal}, op);
      chk("r_res", oALUresult, expRes(op, a, b, sh));
      chk("r_zero", {31'b0, oZero}, {31'b0, expRes(op, a, b, sh) == 32'h0});
      chk("r_ovf", {31'b0, oOverflow}, {31'b0, expOvf(op, a, b)});
      chk("r_rd", oReadData, mRead(iReadRegister));
      chk("r_disp", oRegDisp, mRead(iRegDispSelect));
      chk("r_im", {24'b0, oInterruptMask},
          {24'b0, (mStatus[0] && !mStatus[1]) ? (mIp & mStatus[15:8]) : 8'h0});
      chk("r_um", {31'b0, oUserMode}, {31'b0, mStatus[4]});
      chk("r_exl", {31'b0, oExcLevel}, {31'b0, mStatus[1]});

      // Model next state
      begin
        longint p;
        logic [63:0] pu;
        int sa, sb;
        sa = a; sb = b;
        case (op)
          17: begin p = longint'(sa) * longint'(sb); {mHi, mLo} = p; end
          18: begin pu = 64'(a) * 64'(b); {mHi, mLo} = pu; end
          19: if (b != 0) begin mLo = sa / sb; mHi = sa % sb; end
          20: if (b != 0) begin mLo = a / b; mHi = a % b; end
          23: mHi = a;
          24: mLo = a;
          default: ;
        endcase
        mIp = iPendingInterrupt;
        if (iExcOccurred) begin
          mEpc = iWriteData; mCode = iExcCode; mBd = iBranchDelay; mStatus[1] = 1'b1;
        end else if (iEret) begin
          mStatus[1] = 1'b0;
        end else if (iRegWrite) begin
          if (iWriteRegister == 5'd12) mStatus = iWriteData;
          else if (iWriteRegister == 5'd14) mEpc = iWriteData;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
